muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning cycles Busy stays high for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning cycles Busy stays high for DIV/DIVU.
REQ-003 SHALL have port Clk  input  1  the single clock; all state updates on posedge Clk.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset, sampled on posedge Clk.
REQ-005 SHALL have port A  input  32  operand from GRF Rd1 (rs).
REQ-006 SHALL have port B  input  32  operand from GRF Rd2 (rt).
REQ-007 SHALL have port Op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
REQ-008 SHALL have port Start  input  1  one-cycle request qualifying Op, A and B.
REQ-009 SHALL have port Busy  output  1  high while an arithmetic operation is in progress.
REQ-010 SHALL have port HI  output  32  HI register value; feeds GRF Wd for MFHI.
REQ-011 SHALL have port LO  output  32  LO register value; feeds GRF Wd for MFLO.

Function
REQ-012 SHALL have two states, IDLE and RUN, plus a down-counter of at least 4 bits.
REQ-013 SHALL, in IDLE with Start=1 and Op in 0..3 at a posedge, latch A, B and Op, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN; Busy SHALL be 1 from the next cycle.
REQ-014 SHALL, in RUN, decrement the counter each posedge; on the posedge where it reaches 0, update HI/LO, return to IDLE and drive Busy=0, all at that same edge.
REQ-015 SHALL yield total latency N cycles: Busy high for exactly N cycles after the Start edge, with results visible on HI/LO in the first cycle Busy=0.
REQ-016 SHALL, for MULT/MULTU, compute the 64-bit product (signed/unsigned); HI={product[63:32]}, LO={product[31:0]}.
REQ-017 SHALL, for DIV/DIVU, set LO=quotient and HI=remainder; signed quotient truncates toward zero, remainder takes the dividend's sign.
REQ-018 SHALL, for DIV with A=0x80000000 and B=0xFFFFFFFF, give LO=0x80000000 and HI=0x00000000.
REQ-019 SHALL, for DIV/DIVU with B=0, run the full DIV_CYCLES with HI and LO left unchanged.
REQ-020 SHALL, in IDLE with Start=1 and Op=4 (MTHI) or Op=5 (MTLO), write A into HI or LO at that posedge, with no change to Busy.
REQ-021 SHALL ignore Start, for every Op, while Busy=1; latched operands SHALL be unaffected by input changes during RUN.
REQ-022 SHALL treat Op 6/7 with Start=1 as no-ops, with no state change.
REQ-023 SHALL keep HI/LO stable at all times except on a completing edge, an MTHI/MTLO edge, or reset.
REQ-024 SHALL drive HI, LO and Busy directly from registers, with no combinational path from inputs.

Reset
REQ-025 SHALL, on posedge Clk with Reset=1, set HI=0, LO=0, Busy=0, counter=0 and state=IDLE, with priority over all other inputs.
REQ-026 SHALL, when reset occurs mid-RUN, abort the operation with no HI/LO update, and accept a new Start on the first edge after Reset falls.
REQ-027 SHALL preset HI and LO to 0 at time zero (initial) as well.

Verification
REQ-028 Reset, then MULT A=0xFFFFFFFE(-2), B=3 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-029 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-030 DIV A=0xFFFFFFF9(-7), B=2 -> Busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-031 MTLO A=0x12345678 with Start in IDLE -> LO=0x12345678 next cycle, Busy stays 0; MTHI issued while Busy=1 -> HI unchanged.
REQ-032 DIV with B=0 after HI=0xA, LO=0xB -> Busy high 10 cycles, then HI=0xA, LO=0xB.
REQ-033 Start MULT, assert Reset on cycle 3 of RUN -> Busy=0, HI=LO=0 on the next edge; a new MULT 2*3 then gives LO=6 after 5 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO pair; arithmetic ops run for
// a fixed number of cycles while MTHI/MTLO write HI/LO in a single edge.
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  Op,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  // Start is a one-cycle request: it qualifies Op/A/B at a posedge only while
  // Busy=0; every request seen while Busy=1 is dropped without effect.
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [15:0] MULT_LOAD = 16'(MULT_CYCLES);
  localparam logic [15:0] DIV_LOAD  = 16'(DIV_CYCLES);

  state_t      state_q = IDLE;
  state_t      state_d;
  logic [15:0] cnt_q = '0;
  logic [15:0] cnt_d;
  logic [31:0] hi_q = '0;
  logic [31:0] lo_q = '0;
  logic [31:0] hi_d, lo_d;
  logic        busy_q = 1'b0;
  logic        busy_d;
  logic [31:0] a_q = '0;
  logic [31:0] b_q = '0;
  logic [1:0]  op_q = '0;
  logic [31:0] a_d, b_d;
  logic [1:0]  op_d;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [63:0] prod;
  logic               is_signed;
  logic               a_neg, b_neg;
  logic        [31:0] a_mag, b_mag, b_safe;
  logic        [31:0] q_mag, r_mag, quot, rem;

  // Signed divide works on magnitudes, so INT_MIN / -1 wraps to INT_MIN naturally.
  always_comb begin
    is_signed = ~op_q[0];
    prod_s    = $signed(a_q) * $signed(b_q);
    prod_u    = {32'd0, a_q} * {32'd0, b_q};
    prod      = is_signed ? prod_s : prod_u;
    a_neg     = is_signed & a_q[31];
    b_neg     = is_signed & b_q[31];
    a_mag     = a_neg ? -a_q : a_q;
    b_mag     = b_neg ? -b_q : b_q;
    b_safe    = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag     = a_mag / b_safe;
    r_mag     = a_mag % b_safe;
    quot      = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem       = a_neg ? -r_mag : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          case (Op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              a_d     = A;
              b_d     = B;
              op_d    = Op[1:0];
              cnt_d   = Op[1] ? DIV_LOAD : MULT_LOAD;
              state_d = RUN;
              busy_d  = 1'b1;
            end
            3'd4:    hi_d = A;
            3'd5:    lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q <= 16'd1) begin
          cnt_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
          if (!op_q[1]) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, HI/LO results, MTHI/MTLO,
// ignored requests while busy, divide-by-zero and mid-run reset.
module tb_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] A, B;
  logic [2:0]  Op;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk), .Reset(Reset), .A(A), .B(B), .Op(Op),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver: one-cycle request, launched from a negedge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // count cycles Busy stays high, starting at the negedge after the Start edge
  task automatic count_busy(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      n++;
      @(negedge Clk);
    end
  endtask

  // scoreboard: arithmetic op with expected {HI,LO} queued, checked at completion
  task automatic run_arith(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int cycles, input logic [63:0] exp);
    int n;
    logic [63:0] e;
    exp_q.push_back(exp);
    issue(op, a, b);
    count_busy(n);
    check({tag, " busy"}, 32'(n), 32'(cycles));
    e = exp_q.pop_front();
    check({tag, " HI"}, HI, e[63:32]);
    check({tag, " LO"}, LO, e[31:0]);
  endtask

  initial begin
    int n;
    Reset = 1'b1;
    Start = 1'b0;
    Op    = 3'd7;
    A     = '0;
    B     = '0;
    do_reset();
    @(negedge Clk);
    check("reset busy", {31'd0, Busy}, 32'd0);
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);

    run_arith("mult -2*3", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 64'hFFFF_FFFF_FFFF_FFFA);
    run_arith("multu max*max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 64'hFFFF_FFFE_0000_0001);
    run_arith("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 64'hFFFF_FFFF_FFFF_FFFD);
    run_arith("divu 7/2", 3'd3, 32'd7, 32'd2, 10, 64'h0000_0001_0000_0003);
    run_arith("div 7/-2", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 64'h0000_0001_FFFF_FFFD);
    run_arith("div min/-1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 64'h0000_0000_8000_0000);
    run_arith("multu 0x10000^2", 3'd1, 32'h0001_0000, 32'h0001_0000, 5, 64'h0000_0001_0000_0000);

    // MTLO in idle: one-edge write, Busy untouched
    issue(3'd5, 32'h1234_5678, 32'd0);
    check("mtlo LO", LO, 32'h1234_5678);
    check("mtlo busy", {31'd0, Busy}, 32'd0);
    check("mtlo HI kept", HI, 32'h0000_0001);

    // no-op opcodes leave everything alone
    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    issue(3'd7, 32'hDEAD_BEEF, 32'd1);
    check("nop busy", {31'd0, Busy}, 32'd0);
    check("nop HI", HI, 32'h0000_0001);
    check("nop LO", LO, 32'h1234_5678);

    // MTHI and operand changes while busy must be ignored
    issue(3'd0, 32'd100, 32'd200);
    Start = 1'b1;
    Op    = 3'd4;
    A     = 32'hCAFE_0000;
    B     = 32'd9;
    @(negedge Clk);
    Op    = 3'd3;
    A     = 32'd1;
    @(negedge Clk);
    Start = 1'b0;
    check("mthi busy HI", HI, 32'h0000_0001);
    count_busy(n);
    check("busy-ignore cycles", 32'(n), 32'd3);
    check("busy-ignore HI", HI, 32'd0);
    check("busy-ignore LO", LO, 32'd20000);

    // divide by zero: full latency, HI/LO preserved
    issue(3'd4, 32'h0000_000A, 32'd0);
    issue(3'd5, 32'h0000_000B, 32'd0);
    run_arith("div by 0", 3'd2, 32'd55, 32'd0, 10, 64'h0000_000A_0000_000B);
    run_arith("divu by 0", 3'd3, 32'd55, 32'd0, 10, 64'h0000_000A_0000_000B);

    // reset during the third RUN cycle aborts without a result
    issue(3'd0, 32'd5, 32'd7);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("abort busy", {31'd0, Busy}, 32'd0);
    check("abort HI", HI, 32'd0);
    check("abort LO", LO, 32'd0);
    Reset = 1'b0;
    run_arith("mult after reset", 3'd0, 32'd2, 32'd3, 5, 64'h0000_0000_0000_0006);

    check("queue drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
